mem_port_arbiter: RTL and testbench

- Shares the single memory port of the core between the instruction-fetch requester and the load/store (data) requester.
- Round-robin arbitration; one outstanding transaction at a time.
- Registered request/acknowledge handshake on each side; wait states via m_ready.
- Timeout abort so a dead memory cannot hang the pipeline.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store requesters. Round-robin, one outstanding access, registered
// handshakes, and a timeout abort so a dead memory cannot stall the core.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err,
  output logic              err_port
);

  // A zero timeout disables the counter compare; keep at least one bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_m_req, w_m_req_nxt;
  logic              r_m_we, w_m_we_nxt;
  logic [ADDR_W-1:0] r_m_addr, w_m_addr_nxt;
  logic [DATA_W-1:0] r_m_wdata, w_m_wdata_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
  logic              r_if_ack, w_if_ack_nxt;
  logic              r_d_ack, w_d_ack_nxt;
  logic              r_err, w_err_nxt;
  logic              r_err_port, w_err_port_nxt;
  logic              r_last_d, w_last_d_nxt;   // 1 = last grant went to data
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic w_if_elig, w_d_elig, w_pick_d, w_busy_d, w_timeout;

  // A port in its ack cycle is not eligible: that cycle belongs to the requester.
  assign w_if_elig = if_req & ~r_if_ack;
  assign w_d_elig  = d_req & ~r_d_ack;
  // Data wins if alone, or on a tie when fetch had the previous grant.
  assign w_pick_d  = w_d_elig & (~w_if_elig | ~r_last_d);
  assign w_busy_d  = (r_state == BUSY_D);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LIM);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_m_req_nxt    = r_m_req;
    w_m_we_nxt     = r_m_we;
    w_m_addr_nxt   = r_m_addr;
    w_m_wdata_nxt  = r_m_wdata;
    w_if_rdata_nxt = r_if_rdata;
    w_d_rdata_nxt  = r_d_rdata;
    w_if_ack_nxt   = 1'b0;
    w_d_ack_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_port_nxt = r_err_port;
    w_last_d_nxt   = r_last_d;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_if_elig || w_d_elig) begin
          w_m_req_nxt  = 1'b1;
          w_last_d_nxt = w_pick_d;
          w_cnt_nxt    = '0;
          if (w_pick_d) begin
            w_m_addr_nxt  = d_addr;
            w_m_we_nxt    = d_we;
            w_m_wdata_nxt = d_wdata;
            w_state_nxt   = BUSY_D;
          end else begin
            w_m_addr_nxt  = if_addr;
            w_m_we_nxt    = 1'b0;
            w_state_nxt   = BUSY_IF;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (m_ready) begin
          // Normal completion; ready beats a coincident timeout.
          w_m_req_nxt = 1'b0;
          w_m_we_nxt  = 1'b0;
          w_state_nxt = IDLE;
          if (w_busy_d) begin
            w_d_ack_nxt = 1'b1;
            if (!r_m_we) begin
              w_d_rdata_nxt = m_rdata;
            end else begin
              w_d_rdata_nxt = r_d_rdata;
            end
          end else begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = m_rdata;
          end
        end else if (w_timeout) begin
          // Abort: complete the requester with zero data and flag the error.
          w_m_req_nxt    = 1'b0;
          w_m_we_nxt     = 1'b0;
          w_state_nxt    = IDLE;
          w_err_nxt      = 1'b1;
          w_err_port_nxt = w_busy_d;
          if (w_busy_d) begin
            w_d_ack_nxt   = 1'b1;
            w_d_rdata_nxt = '0;
          end else begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = '0;
          end
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_m_req_nxt = 1'b0;
        w_m_we_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_err      <= 1'b0;
      r_err_port <= 1'b0;
      r_last_d   <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_m_req    <= w_m_req_nxt;
      r_m_we     <= w_m_we_nxt;
      r_m_addr   <= w_m_addr_nxt;
      r_m_wdata  <= w_m_wdata_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
      r_if_ack   <= w_if_ack_nxt;
      r_d_ack    <= w_d_ack_nxt;
      r_err      <= w_err_nxt;
      r_err_port <= w_err_port_nxt;
      r_last_d   <= w_last_d_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign if_ack   = r_if_ack;
  assign d_ack    = r_d_ack;
  assign err      = r_err;
  assign err_port = r_err_port;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, m_ready;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, d_ack, m_req, m_we, err, err_port;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: is a transaction open, whose is it, how long it has waited.
  int          mdl_busy, mdl_owner_d, mdl_last_d, mdl_low;
  logic        e_m_req, e_m_we, e_if_ack, e_d_ack, e_err, e_err_port;
  logic [31:0] e_m_addr, e_m_wdata, e_if_rdata, e_d_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .err(err), .err_port(err_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_busy = 0; mdl_owner_d = 0; mdl_last_d = 1; mdl_low = 0;
    e_m_req = 1'b0; e_m_we = 1'b0; e_if_ack = 1'b0; e_d_ack = 1'b0;
    e_err = 1'b0; e_err_port = 1'b0;
    e_m_addr = 32'h0; e_m_wdata = 32'h0; e_if_rdata = 32'h0; e_d_rdata = 32'h0;
  endtask

  // Predict the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    bit el_if, el_d, pick_d;
    el_if = if_req && !e_if_ack;
    el_d  = d_req && !e_d_ack;
    e_if_ack = 1'b0; e_d_ack = 1'b0; e_err = 1'b0;
    if (mdl_busy == 0) begin
      if (el_if || el_d) begin
        pick_d = (el_if && el_d) ? (mdl_last_d == 0) : el_d;
        mdl_busy = 1; mdl_owner_d = int'(pick_d); mdl_last_d = int'(pick_d); mdl_low = 0;
        e_m_req = 1'b1;
        if (pick_d) begin
          e_m_addr = d_addr; e_m_we = d_we; e_m_wdata = d_wdata;
        end else begin
          e_m_addr = if_addr; e_m_we = 1'b0;
        end
      end
    end else if (m_ready) begin
      if (mdl_owner_d == 1) begin
        e_d_ack = 1'b1;
        if (!e_m_we) e_d_rdata = m_rdata;
      end else begin
        e_if_ack = 1'b1; e_if_rdata = m_rdata;
      end
      mdl_busy = 0; e_m_req = 1'b0; e_m_we = 1'b0;
    end else if (TO != 0 && mdl_low == TO) begin
      if (mdl_owner_d == 1) begin
        e_d_ack = 1'b1; e_d_rdata = 32'h0;
      end else begin
        e_if_ack = 1'b1; e_if_rdata = 32'h0;
      end
      e_err = 1'b1; e_err_port = (mdl_owner_d == 1);
      mdl_busy = 0; e_m_req = 1'b0; e_m_we = 1'b0;
    end else begin
      mdl_low++;
    end
  endtask

  task automatic compare_all();
    chk("m_req", {31'h0, m_req}, {31'h0, e_m_req});
    chk("m_we", {31'h0, m_we}, {31'h0, e_m_we});
    chk("m_addr", m_addr, e_m_addr);
    chk("m_wdata", m_wdata, e_m_wdata);
    chk("if_ack", {31'h0, if_ack}, {31'h0, e_if_ack});
    chk("d_ack", {31'h0, d_ack}, {31'h0, e_d_ack});
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("err", {31'h0, err}, {31'h0, e_err});
    chk("err_port", {31'h0, err_port}, {31'h0, e_err_port});
  endtask

  // One clock: predict, advance past the edge, compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0;
    model_reset();
    #12;
    chk("rst_m_req", {31'h0, m_req}, 32'h0);
    chk("rst_acks", {30'h0, if_ack, d_ack}, 32'h0);
    chk("rst_err", {30'h0, err, err_port}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    reset = 1'b0;

    // Single fetch with immediate ready.
    if_req = 1'b1; if_addr = 32'h0000_0100;
    tick();
    chk("f1_m_req", {31'h0, m_req}, 32'h1);
    chk("f1_m_addr", m_addr, 32'h0000_0100);
    chk("f1_m_we", {31'h0, m_we}, 32'h0);
    m_ready = 1'b1; m_rdata = 32'h0050_0093;
    tick();
    chk("f1_if_ack", {31'h0, if_ack}, 32'h1);
    chk("f1_if_rdata", if_rdata, 32'h0050_0093);
    chk("f1_m_req_low", {31'h0, m_req}, 32'h0);
    if_req = 1'b0; m_ready = 1'b0;
    tick();

    // Both ports requesting continuously: grants alternate, fetch first.
    pulse_reset();
    if_req = 1'b1; if_addr = 32'h0000_0104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
    m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) begin
        chk("alt_m_req", {31'h0, m_req}, 32'h1);
        if (k % 4 == 1) begin
          chk("alt_if_addr", m_addr, 32'h0000_0104);
        end else begin
          chk("alt_d_addr", m_addr, 32'h0000_2000);
          chk("alt_d_we", {31'h0, m_we}, 32'h1);
          chk("alt_d_wdata", m_wdata, 32'hDEAD_BEEF);
        end
      end else if (k % 4 == 2) begin
        chk("alt_if_ack", {31'h0, if_ack}, 32'h1);
      end else begin
        chk("alt_d_ack", {31'h0, d_ack}, 32'h1);
        chk("alt_d_rdata_kept", d_rdata, 32'h0);
      end
    end
    if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    tick();

    // Load with three wait states.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ws_m_req", {31'h0, m_req}, 32'h1);
      chk("ws_m_addr", m_addr, 32'h0000_3000);
    end
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    chk("ws_d_ack", {31'h0, d_ack}, 32'h1);
    chk("ws_d_rdata", d_rdata, 32'h1234_5678);
    chk("ws_err", {31'h0, err}, 32'h0);
    d_req = 1'b0; m_ready = 1'b0;
    tick();

    // Dead memory: load aborts after TO low cycles.
    d_req = 1'b1; d_addr = 32'h0000_4000;
    tick();
    for (int k = 0; k < TO; k++) begin
      tick();
      chk("to_wait_m_req", {31'h0, m_req}, 32'h1);
      chk("to_wait_err", {31'h0, err}, 32'h0);
    end
    tick();
    chk("to_m_req", {31'h0, m_req}, 32'h0);
    chk("to_d_ack", {31'h0, d_ack}, 32'h1);
    chk("to_d_rdata", d_rdata, 32'h0);
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_err_port", {31'h0, err_port}, 32'h1);
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0500;
    tick();
    m_ready = 1'b1; m_rdata = 32'h1111_2222;
    tick();
    chk("to_f_ack", {31'h0, if_ack}, 32'h1);
    chk("to_f_rdata", if_rdata, 32'h1111_2222);
    chk("to_f_err", {31'h0, err}, 32'h0);
    chk("to_f_err_port", {31'h0, err_port}, 32'h1);

    // Ready arrives exactly on the timeout cycle: normal completion.
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h0000_6000; m_ready = 1'b0;
    tick();
    for (int k = 0; k < TO; k++) tick();
    m_ready = 1'b1; m_rdata = 32'hA5A5_5A5A;
    tick();
    chk("edge_d_ack", {31'h0, d_ack}, 32'h1);
    chk("edge_d_rdata", d_rdata, 32'hA5A5_5A5A);
    chk("edge_err", {31'h0, err}, 32'h0);
    d_req = 1'b0; m_ready = 1'b0;
    tick();

    // Reset in the middle of a transaction.
    if_req = 1'b1; if_addr = 32'h0000_0700;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_m_req", {31'h0, m_req}, 32'h0);
    chk("arst_acks", {30'h0, if_ack, d_ack}, 32'h0);
    chk("arst_err", {31'h0, err}, 32'h0);
    model_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_7000;
    #3;
    reset = 1'b0;
    tick();
    chk("arst_first_grant", m_addr, 32'h0000_0700);

    // Random traffic; requests are held until acknowledged.
    for (int c = 0; c < 1500; c++) begin
      if (!if_req || e_if_ack) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end
      if (!d_req || e_d_ack) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      m_ready = ($urandom_range(0, 3) == 0);
      m_rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
